// File: rtl/fifo_uart_tx_ctrl_if.sv
// fifo_uart_tx_ctrl_if: FIFO read port plus UART line/status bundle for fifo_uart_tx_ctrl.
// Latency: none, wires only.
// Backpressure: none here; the controller paces reads one frame at a time.
interface fifo_uart_tx_ctrl_if;
  logic       fifo_empty;
  logic       fifo_valid;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;
  logic       rd_err;

  // Environment side: owns the FIFO read port, observes the line and status
  modport master (
    output fifo_empty, fifo_valid, fifo_dout,
    input  fifo_rd_en, uart_tx, tx_busy, tx_done, rd_err
  );

  // Controller side
  modport slave (
    input  fifo_empty, fifo_valid, fifo_dout,
    output fifo_rd_en, uart_tx, tx_busy, tx_done, rd_err
  );
endinterface

// File: rtl/fifo_uart_tx_ctrl.sv
// fifo_uart_tx_ctrl: frame-paced FIFO reader driving an 8N1 UART line, LSB first.
// Latency: empty seen low -> rd_en next cycle -> valid sampled -> start bit; frame is 10*BAUD_DIV cycles.
// Backpressure: one read in flight; the next read waits for the stop bit, so bytes stay in the FIFO.
// Build option: define UART_PARITY_EN to add an even-parity bit after the data (11-bit frame).
module fifo_uart_tx_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 1_562_500,
  parameter int RD_TIMEOUT = 4
) (
  input logic                clk,
  input logic                rst,
  fifo_uart_tx_ctrl_if.slave bus
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int WT_W     = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [WT_W-1:0]  WAIT_LAST = WT_W'(RD_TIMEOUT - 1);

  // Frame states are encoded from START upward so "in frame" is a single compare
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] WAIT_V = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
`ifdef UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd6;
`endif

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [WT_W-1:0]  wait_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rd_err_q;
  logic             tx_line;
  logic             baud_wrap;
  logic             in_frame;
  logic             wait_expired;
`ifdef UART_PARITY_EN
  logic             par_bit;
`endif

  assign baud_wrap    = (baud_cnt == BAUD_LAST);
  assign in_frame     = (state >= START);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Next-state selection; bit-period states leave only on a baud wrap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!bus.fifo_empty) state_nxt = READ;
      // A read is only issued against a non-empty FIFO; otherwise back off
      READ:   state_nxt = bus.fifo_empty ? IDLE : WAIT_V;
      WAIT_V: begin
        if (bus.fifo_valid)     state_nxt = START;
        else if (wait_expired)  state_nxt = IDLE;
      end
      START:  if (baud_wrap) state_nxt = DATA;
      DATA: begin
        if (baud_wrap && (bit_idx == 3'd7)) begin
`ifdef UART_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (baud_wrap) state_nxt = STOP;
`endif
      STOP:   if (baud_wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Baud counter: zero outside frames and on every state entry, wraps at BAUD_DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              baud_cnt <= '0;
    else if (!in_frame || (state_nxt != state) || baud_wrap) baud_cnt <= '0;
    else                                                  baud_cnt <= baud_cnt + CNT_W'(1);
  end

  // Read-wait counter: cleared by the read pulse, counts WAIT_V cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wait_cnt <= '0;
    else if (state == WAIT_V) wait_cnt <= wait_cnt + WT_W'(1);
    else                      wait_cnt <= '0;
  end

  // Data bit index, advancing on each baud wrap within DATA
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             bit_idx <= 3'd0;
    else if (state != DATA)              bit_idx <= 3'd0;
    else if (baud_wrap)                  bit_idx <= bit_idx + 3'd1;
  end

  // Shift register: byte latched once on valid, so later fifo_dout changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  shreg <= 8'h00;
    else if ((state == WAIT_V) && bus.fifo_valid) shreg <= bus.fifo_dout;
    else if ((state == DATA) && baud_wrap)    shreg <= {1'b0, shreg[7:1]};
  end

`ifdef UART_PARITY_EN
  // Even parity captured alongside the byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  par_bit <= 1'b0;
    else if ((state == WAIT_V) && bus.fifo_valid) par_bit <= ^bus.fifo_dout;
  end
`endif

  // Sticky read-timeout flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  rd_err_q <= 1'b0;
    else if ((state == WAIT_V) && !bus.fifo_valid && wait_expired) rd_err_q <= 1'b1;
  end

  // Line level decoded from state; reset forces IDLE, so the line goes high at once
  always_comb begin
    tx_line = 1'b1;
    case (state)
      START:  tx_line = 1'b0;
      DATA:   tx_line = shreg[0];
`ifdef UART_PARITY_EN
      PARITY: tx_line = par_bit;
`endif
      default: tx_line = 1'b1;
    endcase
  end

  assign bus.uart_tx    = tx_line;
  assign bus.fifo_rd_en = (state == READ) && !bus.fifo_empty;
  assign bus.tx_busy    = (state != IDLE);
  assign bus.tx_done    = (state == STOP) && baud_wrap;
  assign bus.rd_err     = rd_err_q;

endmodule

// File: tb/tb_fifo_uart_tx_ctrl.sv
// tb_fifo_uart_tx_ctrl: directed bench for fifo_uart_tx_ctrl with a queue-backed FIFO read port.
// Latency: FIFO answers a read with valid one cycle later (optionally withheld once).
// Backpressure: bench FIFO reports empty whenever its queue is empty.
`define CHK(TAG, OBS, EXP) \
  begin \
    n_chk++; \
    assert ((OBS) === (EXP)) n_pass++; \
    else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
    end \
  end

module tb_fifo_uart_tx_ctrl;
  localparam int BD = 32;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  fifo_uart_tx_ctrl_if bus();

  fifo_uart_tx_ctrl #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (1_562_500),
    .RD_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         n_chk    = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         rd_cnt   = 0;
  int         done_cnt = 0;
  logic [7:0] q[$];
  logic       withhold = 1'b0;

  // One clock: tally rd_en/tx_done of the ending cycle, then play the FIFO's response
  task automatic tick();
    logic rd_seen;
    logic done_seen;
    rd_seen   = bus.fifo_rd_en;
    done_seen = bus.tx_done;
    @(posedge clk);
    #1;
    rd_cnt   += int'(rd_seen);
    done_cnt += int'(done_seen);
    bus.fifo_valid = 1'b0;
    if (rd_seen && (q.size() > 0)) begin
      bus.fifo_dout  = q.pop_front();
      bus.fifo_valid = ~withhold;
      withhold       = 1'b0;
    end
    bus.fifo_empty = (q.size() == 0);
  endtask

  // Called in the first START cycle; checks every bit period and the done pulse
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [NB-1:0] bits;
    int errs;
    int spurious;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_PARITY_EN
    bits[9] = ^b;
`endif
    bits[NB-1] = 1'b1;
    spurious = 0;
    for (int k = 0; k < NB; k++) begin
      errs = 0;
      for (int j = 0; j < BD; j++) begin
        if (bus.uart_tx !== bits[k]) errs++;
        if (bus.tx_busy !== 1'b1) errs++;
        if ((k == NB-1) && (j == BD-1)) `CHK({tag, " done pulse"}, bus.tx_done, 1'b1)
        else if (bus.tx_done !== 1'b0) spurious++;
        // Stray data and a stray valid mid-frame must not disturb the frame
        bus.fifo_dout  = b ^ 8'hFF;
        bus.fifo_valid = (j == 7);
        tick();
      end
      `CHK($sformatf("%s bit%0d", tag, k), errs, 0)
    end
    `CHK({tag, " early done"}, spurious, 0)
    `CHK({tag, " busy after stop"}, bus.tx_busy, 1'b0)
    `CHK({tag, " line after stop"}, bus.uart_tx, 1'b1)
  endtask

  // Called in a cycle where the DUT is IDLE and the FIFO holds b at its head
  task automatic send_expect(input logic [7:0] b, input string tag);
    int rd0;
    rd0 = rd_cnt;
    tick();
    `CHK({tag, " rd_en"}, bus.fifo_rd_en, 1'b1)
    `CHK({tag, " busy at read"}, bus.tx_busy, 1'b1)
    tick();
    `CHK({tag, " rd_en one cycle"}, bus.fifo_rd_en, 1'b0)
    `CHK({tag, " line in wait"}, bus.uart_tx, 1'b1)
    tick();
    `CHK({tag, " start low"}, bus.uart_tx, 1'b0)
    check_frame(b, tag);
    `CHK({tag, " single read"}, rd_cnt - rd0, 1)
  endtask

  initial begin
    int lo;
    int busy;
    int errs;
    int d0;
    int r0;

    // Reset state
    rst            = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_valid = 1'b0;
    bus.fifo_dout  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst uart_tx", bus.uart_tx, 1'b1)
    `CHK("rst tx_busy", bus.tx_busy, 1'b0)
    `CHK("rst rd_en", bus.fifo_rd_en, 1'b0)
    `CHK("rst tx_done", bus.tx_done, 1'b0)
    `CHK("rst rd_err", bus.rd_err, 1'b0)
    rst = 1'b0;

    // Empty FIFO for 1000 cycles: nothing happens
    lo = 0;
    busy = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.uart_tx !== 1'b1) lo++;
      if (bus.tx_busy !== 1'b0) busy++;
      tick();
    end
    `CHK("idle no reads", rd_cnt, 0)
    `CHK("idle line high", lo, 0)
    `CHK("idle not busy", busy, 0)

    // Single byte 0xA5
    d0 = done_cnt;
    q.push_back(8'hA5);
    bus.fifo_empty = 1'b0;
    send_expect(8'hA5, "a5");
    `CHK("a5 done count", done_cnt - d0, 1)

    // Three queued bytes, back to back with one IDLE cycle after each tx_done
    d0 = done_cnt;
    r0 = rd_cnt;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h3C);
    bus.fifo_empty = 1'b0;
    send_expect(8'h00, "b00");
    send_expect(8'hFF, "bff");
    send_expect(8'h3C, "b3c");
    repeat (5) tick();
    `CHK("burst reads", rd_cnt - r0, 3)
    `CHK("burst dones", done_cnt - d0, 3)
    `CHK("burst then idle", bus.tx_busy, 1'b0)

    // Read answered with no valid: timeout after 4 wait cycles, then next byte goes out
    d0 = done_cnt;
    q.push_back(8'h11);
    q.push_back(8'h5A);
    withhold = 1'b1;
    bus.fifo_empty = 1'b0;
    tick();
    `CHK("to rd_en", bus.fifo_rd_en, 1'b1)
    repeat (4) tick();
    `CHK("to rd_err before", bus.rd_err, 1'b0)
    `CHK("to line in wait", bus.uart_tx, 1'b1)
    tick();
    `CHK("to rd_err set", bus.rd_err, 1'b1)
    `CHK("to busy low", bus.tx_busy, 1'b0)
    `CHK("to line high", bus.uart_tx, 1'b1)
    `CHK("to no done", done_cnt - d0, 0)
    send_expect(8'h5A, "b5a");
    `CHK("rd_err sticky", bus.rd_err, 1'b1)

    // Reset in the middle of data bit 4 of 0xC3
    q.push_back(8'hC3);
    bus.fifo_empty = 1'b0;
    repeat (3) tick();
    repeat (BD + 4*BD + 10) tick();
    `CHK("c3 bit4 before rst", bus.uart_tx, 1'b0)
    `CHK("c3 busy before rst", bus.tx_busy, 1'b1)
    q.push_back(8'h96);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    `CHK("mid rst line high", bus.uart_tx, 1'b1)
    `CHK("mid rst busy low", bus.tx_busy, 1'b0)
    `CHK("mid rst rd_err clr", bus.rd_err, 1'b0)
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.uart_tx !== 1'b1) errs++;
      if (bus.fifo_rd_en !== 1'b0) errs++;
      tick();
    end
    `CHK("in rst quiet", errs, 0)
    rst = 1'b0;
    `CHK("rst release no read", bus.fifo_rd_en, 1'b0)
    send_expect(8'h96, "b96");
    `CHK("rst frame dones", done_cnt - d0, 1)

`ifdef UART_PARITY_EN
    // Even parity: 0x07 has odd weight, 0x03 even
    q.push_back(8'h07);
    bus.fifo_empty = 1'b0;
    send_expect(8'h07, "p07");
    q.push_back(8'h03);
    bus.fifo_empty = 1'b0;
    send_expect(8'h03, "p03");
`endif

    repeat (4) tick();
    `CHK("final idle line", bus.uart_tx, 1'b1)
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx_ctrl.md
# fifo_uart_tx_ctrl

Downstream consumer of the counter-to-UART async FIFO: pulls bytes from the FIFO read port with a one-cycle-latency read handshake, then serializes each byte as an 8N1 UART frame (LSB first) at BAUD. It replaces the free-running read enable with a frame-paced read, so no FIFO data is lost between frames. All logic runs in the clk domain, which is the FIFO read clock.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, clk frequency in Hz
- BAUD, 1_562_500, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (32 by default), must be ≥ 4
- RD_TIMEOUT, 4, maximum cycles to wait for fifo_valid after a read

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- fifo_empty  in  1  FIFO empty flag
- fifo_valid  in  1  FIFO read-data valid
- fifo_dout  in  8  FIFO read data
- fifo_rd_en  out  1  FIFO read request, single-cycle pulse
- uart_tx  out  1  serial line, idles high
- tx_busy  out  1  high from the read pulse through the end of the stop bit
- tx_done  out  1  one-cycle pulse at the end of the stop bit
- rd_err  out  1  sticky flag: fifo_valid not seen within RD_TIMEOUT

## Operation
- States: IDLE, READ, WAIT_V, START, DATA, (PARITY), STOP.
- IDLE: if fifo_empty is 0, go to READ.
- READ: assert fifo_rd_en for exactly 1 cycle; go to WAIT_V; clear the wait counter.
- WAIT_V:
  - On the edge where fifo_valid=1, latch fifo_dout into the shift register and go to START.
  - If RD_TIMEOUT cycles elapse without fifo_valid, set rd_err and return to IDLE. No frame is sent.
- START: uart_tx=0 for BAUD_DIV cycles.
- DATA: 8 bits LSB first, each held for BAUD_DIV cycles; a 3-bit index counts 0..7.
- PARITY: present only with the macro (see Configuration).
- STOP: uart_tx=1 for BAUD_DIV cycles. On the last cycle, pulse tx_done and go to IDLE.
- Baud counter: width clog2(BAUD_DIV). Reloads to 0 on every state entry and wraps at BAUD_DIV-1; the bit advances on the wrap.
- fifo_rd_en is never asserted while fifo_empty=1 or outside READ. At most one outstanding read at a time.
- fifo_valid outside WAIT_V is ignored.
- fifo_dout changing mid-frame has no effect, because the byte is latched.
- rd_err clears only on rst.

## Timing
- Reset values: fifo_rd_en=0, uart_tx=1, tx_busy=0, tx_done=0, rd_err=0, state=IDLE, counters=0.
- Latency, with fifo_valid arriving 1 cycle after the read:
  - fifo_empty falls at edge T → fifo_rd_en high T+1 → fifo_valid sampled T+2 → uart_tx low T+3.
- Frame length: 10·BAUD_DIV cycles (320 by default); 11·BAUD_DIV with parity.
- Back-to-back: tx_done at edge E; with the FIFO non-empty, the next fifo_rd_en is at E+1 (IDLE lasts 1 cycle).
  - Minimum inter-frame idle is 3 cycles of uart_tx high beyond the stop bit.
- fifo_empty rising during a frame: the current frame completes and the block then holds in IDLE.
- Reset mid-frame:
  - uart_tx returns high immediately (asynchronous).
  - The in-flight byte is dropped and no tx_done is issued.
  - After rst deasserts, the first read occurs no earlier than 2 edges later.
- tx_busy goes high with fifo_rd_en and low on the cycle after the tx_done pulse.
  - On timeout, tx_busy goes low on return to IDLE.

## Configuration
- UART_PARITY_EN defined:
  - A PARITY state is inserted after DATA for BAUD_DIV cycles, driving even parity (XOR of the 8 data bits).
  - Frame is 11 bits.
- UART_PARITY_EN undefined:
  - No PARITY state; plain 8N1, 10-bit frame.
  - No parity logic is synthesized.

## Test plan
- Reset release, FIFO empty for 1000 cycles → fifo_rd_en never asserted; uart_tx=1, tx_busy=0.
- Single byte 0xA5, valid 1 cycle after the read → uart_tx low at T+3.
  - Bits 1,0,1,0,0,1,0,1, then stop, each held 32 cycles.
  - tx_done pulses once, 320 cycles after the start edge.
- Three bytes 0x00, 0xFF, 0x3C queued → three frames in order with exactly one fifo_rd_en each.
  - Each next fifo_rd_en comes 1 cycle after the prior tx_done.
- fifo_valid withheld after fifo_rd_en → rd_err=1 after 4 cycles; uart_tx stays high; no tx_done.
  - The next byte is still read and sent normally.
- rst pulsed during DATA bit 4 → uart_tx=1 during reset and no tx_done.
  - The following byte is transmitted correctly from the start bit.
- With UART_PARITY_EN, byte 0x07 → parity bit 1 and a 352-cycle frame.
  - Byte 0x03 → parity bit 0.
